// File: rtl/vga_embarcacao_pkg.sv
// Shared board geometry and coordinate helpers for the ship renderers.
// Board is 8x8 cells; cell origins step by PASSO_X/PASSO_Y pixels.
package vga_embarcacao_pkg;

  localparam logic [9:0] ORIGEM_X = 10'd16;
  localparam logic [9:0] PASSO_X  = 10'd62;
  localparam logic [9:0] ORIGEM_Y = 10'd16;
  localparam logic [9:0] PASSO_Y  = 10'd57;
  localparam logic [9:0] LARGURA  = 10'd54;
  localparam logic [9:0] ALTURA   = 10'd49;
  localparam logic [9:0] GRADE    = 10'd8;

  // Raw board coordinates are 1-based; 0 and 9..15 mean "not placed".
  function automatic logic coord_valida(input logic [3:0] v);
    return (v >= 4'd1) && (v <= 4'd8);
  endfunction

endpackage

// File: rtl/vga_embarcacao_n_if.sv
// Pixel-stream and game-state bundle feeding one ship renderer, plus its colour outputs.
// master = timing/game side, slave = renderer.
interface vga_embarcacao_n_if #(
  parameter int TAMANHO = 2
);
  logic                areaAtiva;
  logic [9:0]          linha;
  logic [9:0]          coluna;
  logic [63:0]         posicoesEmbarcacao;
  logic [TAMANHO-1:0]  acertos;
  logic                rgb_r;
  logic                rgb_g;
  logic                rgb_b;
  logic                pixelNavio;

  modport master (
    output areaAtiva, linha, coluna, posicoesEmbarcacao, acertos,
    input  rgb_r, rgb_g, rgb_b, pixelNavio
  );

  modport slave (
    input  areaAtiva, linha, coluna, posicoesEmbarcacao, acertos,
    output rgb_r, rgb_g, rgb_b, pixelNavio
  );
endinterface

// File: rtl/vga_embarcacao_n_celula_mapa.sv
// Combinational cell-to-pixel test: high when (linha, coluna) is strictly inside the
// board cell at (x, y) and both coordinates are valid. Zero latency, no handshake.
module vga_celula_mapa
  import vga_embarcacao_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic [9:0] linha,
  input  logic [9:0] coluna,
  output logic       dentro
);

  logic [9:0] left;
  logic [9:0] top;
  logic       habilitada;

  always_comb begin
    // Row 8 is drawn at the top of the screen, so Y counts upwards.
    left       = ORIGEM_X + PASSO_X * ({6'd0, x} - 10'd1);
    top        = ORIGEM_Y + PASSO_Y * (GRADE - {6'd0, y});
    habilitada = coord_valida(x) && coord_valida(y);
    dentro     = habilitada
                 && (linha  > top)  && (linha  < top  + ALTURA)
                 && (coluna > left) && (coluna < left + LARGURA);
  end

endmodule

// File: rtl/vga_embarcacao_n.sv
// Draws one TAMANHO-cell ship with per-frame coordinate latching, hit/sunk display and blink.
// Pixel to colour latency is one cycle; outputs are registered, no backpressure.
module vga_embarcacao_n
  import vga_embarcacao_pkg::*;
#(
  parameter int           TAMANHO      = 2,
  parameter logic         COR_R        = 1'b1,
  parameter logic         COR_G        = 1'b0,
  parameter logic         COR_B        = 1'b0,
  parameter int           BLINK_FRAMES = 15
) (
  input  logic             clk,
  input  logic             rst,
  vga_embarcacao_n_if.slave bus
);

  localparam int         PW         = 8 * TAMANHO;
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  logic               prev_zero_q, prev_zero_d;
  logic [PW-1:0]      pos_q, pos_d;
  logic [TAMANHO-1:0] hit_q, hit_d;
  logic [7:0]         blink_q, blink_d;
  logic               fase_q, fase_d;
  logic               rgb_r_q, rgb_r_d;
  logic               rgb_g_q, rgb_g_d;
  logic               rgb_b_q, rgb_b_d;
  logic               pixel_q, pixel_d;

  logic               pix_zero;
  logic               fs;
  logic [TAMANHO-1:0] dentro;
  logic               algum_dentro;
  logic               acerto_dentro;
  logic               afundado;

  always_comb begin
    pix_zero    = (bus.linha == 10'd0) && (bus.coluna == 10'd0);
    fs          = pix_zero && !prev_zero_q;
    prev_zero_d = pix_zero;

    // Only the coordinate bits of the cells actually in use are shadowed.
    pos_d   = fs ? bus.posicoesEmbarcacao[3 +: PW] : pos_q;
    hit_d   = fs ? bus.acertos                     : hit_q;

    blink_d = blink_q;
    fase_d  = fase_q;
    if (fs) begin
      if (blink_q == BLINK_LAST) begin
        blink_d = 8'd0;
        fase_d  = !fase_q;
      end else begin
        blink_d = blink_q + 8'd1;
      end
    end
  end

  for (genvar k = 0; k < TAMANHO; k++) begin : g_celula
    vga_celula_mapa u_celula (
      .x      (pos_d[8*k +: 4]),
      .y      (pos_d[8*k+4 +: 4]),
      .linha  (bus.linha),
      .coluna (bus.coluna),
      .dentro (dentro[k])
    );
  end

  always_comb begin
    algum_dentro  = |dentro;
    acerto_dentro = |(dentro & hit_d);
    afundado      = &hit_d;

    rgb_r_d = 1'b0;
    rgb_g_d = 1'b0;
    rgb_b_d = 1'b0;
    pixel_d = 1'b0;
    if (bus.areaAtiva && algum_dentro) begin
      pixel_d = 1'b1;
      if (afundado) begin
        // The mux keeps priority on the dark half of the blink too.
        rgb_r_d = COR_R & !fase_q;
        rgb_g_d = COR_G & !fase_q;
        rgb_b_d = COR_B & !fase_q;
      end else if (acerto_dentro) begin
        rgb_r_d = 1'b1;
        rgb_g_d = 1'b1;
        rgb_b_d = 1'b1;
      end else begin
        rgb_r_d = COR_R;
        rgb_g_d = COR_G;
        rgb_b_d = COR_B;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_zero_q <= 1'b0;
      pos_q       <= '0;
      hit_q       <= '0;
      blink_q     <= 8'd0;
      fase_q      <= 1'b0;
      rgb_r_q     <= 1'b0;
      rgb_g_q     <= 1'b0;
      rgb_b_q     <= 1'b0;
      pixel_q     <= 1'b0;
    end else begin
      prev_zero_q <= prev_zero_d;
      pos_q       <= pos_d;
      hit_q       <= hit_d;
      blink_q     <= blink_d;
      fase_q      <= fase_d;
      rgb_r_q     <= rgb_r_d;
      rgb_g_q     <= rgb_g_d;
      rgb_b_q     <= rgb_b_d;
      pixel_q     <= pixel_d;
    end
  end

  assign bus.rgb_r      = rgb_r_q;
  assign bus.rgb_g      = rgb_g_q;
  assign bus.rgb_b      = rgb_b_q;
  assign bus.pixelNavio = pixel_q;

endmodule

// File: tb/tb_vga_embarcacao_n.sv
// Bench for a two-cell ship with a two-frame blink, checked against a pixel-rule model.
module tb_vga_embarcacao_n;

  localparam int T  = 2;
  localparam int BF = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_embarcacao_n_if #(.TAMANHO(T)) bus ();

  vga_embarcacao_n #(
    .TAMANHO      (T),
    .COR_R        (1'b1),
    .COR_G        (1'b0),
    .COR_B        (1'b0),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model state: what the renderer should have latched at the last frame start.
  logic [63:0]  m_pos;
  logic [T-1:0] m_hit;
  int           m_fs;
  bit           m_prev;

  typedef struct {
    int         l;
    int         c;
    bit         a;
    logic [3:0] e;
    string      nm;
  } vec_t;

  vec_t tbl[10];

  task automatic ck(input string nm, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got rgbp=%b expected rgbp=%b", nm, got, exp);
    end
  endtask

  function automatic logic [63:0] mk_pos(input int x0, input int y0, input int x1, input int y1);
    logic [63:0] p;
    p          = {$urandom, $urandom};
    p[3 +: 4]  = x0[3:0];
    p[7 +: 4]  = y0[3:0];
    p[11 +: 4] = x1[3:0];
    p[15 +: 4] = y1[3:0];
    return p;
  endfunction

  // Expected {r,g,b,pixelNavio} straight from the geometric rules.
  function automatic logic [3:0] model_px(input int l, input int c, input bit a);
    bit any_in = 0;
    bit hit_in = 0;
    bit sunk   = 1;
    bit fase;
    int x, y, left, top;
    for (int k = 0; k < T; k++) begin
      x = int'(m_pos[3 + 8*k +: 4]);
      y = int'(m_pos[7 + 8*k +: 4]);
      if (!m_hit[k]) sunk = 0;
      if (x >= 1 && x <= 8 && y >= 1 && y <= 8) begin
        left = 16 + 62 * (x - 1);
        top  = 16 + 57 * (8 - y);
        if (l > top && l < top + 49 && c > left && c < left + 54) begin
          any_in = 1;
          if (m_hit[k]) hit_in = 1;
        end
      end
    end
    fase = ((m_fs / BF) % 2) == 1;
    if (!a || !any_in) return 4'b0000;
    if (sunk)          return fase ? 4'b0001 : 4'b1001;
    if (hit_in)        return 4'b1111;
    return 4'b1001;
  endfunction

  task automatic step(input int l, input int c, input bit a,
                      output logic [3:0] got, output logic [3:0] exp);
    bit zero;
    bus.linha     = 10'(l);
    bus.coluna    = 10'(c);
    bus.areaAtiva = a;
    zero = (l == 0) && (c == 0);
    if (zero && !m_prev) begin
      m_pos = bus.posicoesEmbarcacao;
      m_hit = bus.acertos;
      m_fs++;
    end
    m_prev = zero;
    exp = model_px(l, c, a);
    @(posedge clk);
    #1;
    got = {bus.rgb_r, bus.rgb_g, bus.rgb_b, bus.pixelNavio};
  endtask

  task automatic stepm(input int l, input int c, input bit a, input string nm);
    logic [3:0] g, e;
    step(l, c, a, g, e);
    ck(nm, g, e);
  endtask

  task automatic stepk(input int l, input int c, input bit a, input logic [3:0] e, input string nm);
    logic [3:0] g, me;
    step(l, c, a, g, me);
    ck(nm, g, e);
  endtask

  task automatic new_frame();
    stepm(524, 799, 0, "pre_fs");
    stepm(0, 0, 1, "fs_pixel");
  endtask

  task automatic model_reset();
    m_pos  = '0;
    m_hit  = '0;
    m_fs   = 0;
    m_prev = 0;
  endtask

  initial begin
    int rx[T];
    int ry[T];
    int k, l, c;

    tbl[0] = '{17,  17, 1'b1, 4'b1001, "corner_in"};
    tbl[1] = '{16,  17, 1'b1, 4'b0000, "top_border"};
    tbl[2] = '{17,  16, 1'b1, 4'b0000, "left_border"};
    tbl[3] = '{17,  70, 1'b1, 4'b0000, "right_border"};
    tbl[4] = '{17,  69, 1'b1, 4'b1001, "right_last_in"};
    tbl[5] = '{64,  69, 1'b1, 4'b1001, "bottom_last_in"};
    tbl[6] = '{65,  69, 1'b1, 4'b0000, "bottom_border"};
    tbl[7] = '{40,  40, 1'b0, 4'b0000, "area_off"};
    tbl[8] = '{40,  80, 1'b1, 4'b0000, "next_col_empty"};
    tbl[9] = '{100, 40, 1'b1, 4'b0000, "next_row_empty"};

    model_reset();
    bus.areaAtiva          = 1'b0;
    bus.linha              = 10'd5;
    bus.coluna             = 10'd5;
    bus.posicoesEmbarcacao = mk_pos(1, 8, 0, 0);
    bus.acertos            = '0;
    repeat (2) @(posedge clk);
    #1;
    ck("reset_state", {bus.rgb_r, bus.rgb_g, bus.rgb_b, bus.pixelNavio}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;

    // No frame start since reset: shadow is empty even though a ship is presented.
    stepk(17, 17, 1, 4'b0000, "no_fs_yet");

    new_frame();
    for (int i = 0; i < 10; i++) stepk(tbl[i].l, tbl[i].c, tbl[i].a, tbl[i].e, tbl[i].nm);

    // Asynchronous reset mid-line clears the outputs without a clock edge.
    stepk(17, 17, 1, 4'b1001, "pre_reset_draw");
    #2 rst = 1'b1;
    #1 ck("reset_async", {bus.rgb_r, bus.rgb_g, bus.rgb_b, bus.pixelNavio}, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    stepk(17, 17, 1, 4'b0000, "post_reset_dark");
    stepk(40, 40, 1, 4'b0000, "post_reset_dark2");

    // Tear-free move: X=1 -> X=8 changed at row 200, Y=4 (rows 245..292).
    bus.posicoesEmbarcacao = mk_pos(1, 4, 0, 0);
    new_frame();
    stepk(100, 17, 1, 4'b0000, "tear_above");
    bus.posicoesEmbarcacao = mk_pos(8, 4, 0, 0);
    stepk(200, 17, 1, 4'b0000, "tear_change_row");
    stepk(250, 17, 1, 4'b1001, "tear_old_pos");
    stepk(250, 451, 1, 4'b0000, "tear_new_not_yet");
    new_frame();
    stepk(250, 17, 1, 4'b0000, "tear_old_gone");
    stepk(250, 451, 1, 4'b1001, "tear_new_pos");

    // Invalid coordinates on cell 1 never draw; cell 0 unaffected.
    bus.posicoesEmbarcacao = mk_pos(2, 2, 0, 5);
    new_frame();
    stepk(360, 80, 1, 4'b1001, "inv_cell0_ok");
    stepk(190, 20, 1, 4'b0000, "inv_x0");
    bus.posicoesEmbarcacao = mk_pos(2, 2, 3, 9);
    new_frame();
    stepk(360, 80, 1, 4'b1001, "inv_cell0_ok2");
    stepm(20, 142, 1, "inv_y9");

    // Hit cell shows white, the other stays ship colour.
    bus.posicoesEmbarcacao = mk_pos(1, 8, 2, 8);
    bus.acertos            = 2'b01;
    new_frame();
    stepk(20, 20, 1, 4'b1111, "hit_cell0_white");
    stepk(20, 80, 1, 4'b1001, "hit_cell1_red");
    // Sinking mid-frame takes effect only at the next frame start.
    bus.acertos = 2'b11;
    stepk(30, 20, 1, 4'b1111, "sunk_deferred");
    for (int f = 0; f < 8; f++) begin
      new_frame();
      stepm(20, 20, 1, "sunk_cell0");
      stepm(20, 80, 1, "sunk_cell1");
    end
    stepk(20, 20, 0, 4'b0000, "sunk_area_off");

    // Overlap: hit on either overlapping cell wins.
    bus.posicoesEmbarcacao = mk_pos(5, 5, 5, 5);
    bus.acertos            = 2'b10;
    new_frame();
    stepk(200, 270, 1, 4'b1111, "overlap_hit_wins");

    // Randomised frames with mid-frame changes and held frame-start pixels.
    for (int f = 0; f < 60; f++) begin
      for (int j = 0; j < T; j++) begin
        rx[j] = $urandom_range(0, 9);
        ry[j] = $urandom_range(0, 9);
      end
      bus.posicoesEmbarcacao = mk_pos(rx[0], ry[0], rx[1], ry[1]);
      bus.acertos            = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'($urandom);
      new_frame();
      if ($urandom_range(0, 3) == 0) stepm(0, 0, 1, "rnd_fs_hold");
      for (int p = 0; p < 40; p++) begin
        if (p == 20 && $urandom_range(0, 3) == 0) begin
          bus.posicoesEmbarcacao = mk_pos($urandom_range(0, 9), $urandom_range(0, 9),
                                          $urandom_range(0, 9), $urandom_range(0, 9));
          bus.acertos            = 2'($urandom);
        end
        k = $urandom_range(0, T - 1);
        if (rx[k] >= 1 && rx[k] <= 8 && ry[k] >= 1 && ry[k] <= 8) begin
          l = 16 + 57 * (8 - ry[k]) + $urandom_range(0, 50);
          c = 16 + 62 * (rx[k] - 1) + $urandom_range(0, 55);
        end else begin
          l = $urandom_range(1, 479);
          c = $urandom_range(1, 639);
        end
        stepm(l, c, ($urandom_range(0, 9) != 0), "rnd_pixel");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
